// File: rtl/rv_pkg.sv
// Shared constants for the RISC-V fetch datapath.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT     = 64;
  localparam int unsigned ILEN             = 32;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} pairs with push/pop/flush and a head
// output that reads as zero whenever the queue is empty.
module fetch_queue #(
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic               full,
  output logic               head_valid,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = PC_W + INSTR_W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push    = push && !flush;
  assign do_pop     = pop && !flush && head_valid;
  assign full       = (count_q == CW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_pc    = head_valid ? mem_q[rd_ptr_q][EW-1:INSTR_W] : '0;
  assign head_instr = head_valid ? mem_q[rd_ptr_q][INSTR_W-1:0]  : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Discard everything by snapping the read side onto the write side.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = {push_pc, push_instr};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled fetch front end: PC generator, fetch queue toward decode,
// redirect flush and a saturating fetched-instruction counter.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [31:0]     fetch_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            push, pop, full, head_valid;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  assign imem_addr   = pc_q;
  assign out_valid   = reset && head_valid && !redirect_valid;
  assign out_pc      = reset ? head_pc    : '0;
  assign out_instr   = reset ? head_instr : '0;
  assign fetch_count = fetch_count_q;
  assign pop         = out_valid && out_ready;
  assign push        = !redirect_valid && (!full || pop);

  fetch_queue #(
    .PC_W    (XLEN),
    .INSTR_W (ILEN),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (pc_q),
    .push_instr (imem_rdata),
    .full       (full),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  always_comb begin
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end else if (push) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
      if (fetch_count_q != '1) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a queue-based model.
module tb_instr_fetch_unit;
  import rv_pkg::*;

  localparam int unsigned XL    = 64;
  localparam int unsigned IL    = 32;
  localparam int unsigned DEP   = 4;
  localparam logic [XL-1:0] RPC = 64'h0;
  localparam logic [XL-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic          clk;
  logic          reset;
  logic [XL-1:0] imem_addr;
  logic [IL-1:0] imem_rdata;
  logic          redirect_valid;
  logic [XL-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [XL-1:0] out_pc;
  logic [IL-1:0] out_instr;
  logic [31:0]   fetch_count;

  logic [XL-1:0] w_imem_addr;
  logic          w_out_valid;
  logic [XL-1:0] w_out_pc;
  logic [IL-1:0] w_out_instr;
  logic [31:0]   w_fetch_count;

  instr_fetch_unit #(.XLEN(XL), .DEPTH(DEP), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.XLEN(XL), .DEPTH(DEP), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_rdata(NOP_INSTR),
    .redirect_valid(1'b0), .redirect_pc('0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc),
    .out_instr(w_out_instr), .fetch_count(w_fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: NOP everywhere, or an address hash in "scrambled" mode.
  int unsigned mem_mode;
  function automatic logic [IL-1:0] mem_word(input logic [XL-1:0] a);
    if (mem_mode == 0) return NOP_INSTR;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction
  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic [XL-1:0] pc;
    logic [IL-1:0] ins;
  } ent_t;

  ent_t          mq[$];
  logic [XL-1:0] mpc;
  logic [31:0]   mfc;
  bit            init;
  int            n_cmp;
  int            n_fail;

  task automatic chk(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks all outputs just before the next edge, then advances the model across it.
  task automatic cycle();
    bit pop;
    bit push;
    #2;
    if (!reset) begin
      chk("rst_out_valid", {63'b0, out_valid}, '0);
      chk("rst_out_pc", out_pc, '0);
      chk("rst_out_instr", {32'b0, out_instr}, '0);
    end else if (init) begin
      chk("out_valid", {63'b0, out_valid}, {63'b0, (mq.size() > 0) && !redirect_valid});
      chk("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : '0);
      chk("out_instr", {32'b0, out_instr}, {32'b0, (mq.size() > 0) ? mq[0].ins : 32'h0});
      chk("imem_addr", imem_addr, mpc);
      chk("fetch_count", {32'b0, fetch_count}, {32'b0, mfc});
    end
    if (!reset) begin
      mq.delete();
      mpc  = RPC;
      mfc  = 0;
      init = 1;
    end else if (init) begin
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[XL-1:2], 2'b00};
      end else begin
        pop  = (mq.size() > 0) && out_ready;
        push = (mq.size() < DEP) || pop;
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back('{pc: mpc, ins: mem_word(mpc)});
          mpc = mpc + 64'd4;
          if (mfc != 32'hFFFF_FFFF) mfc = mfc + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  logic [31:0] fc_before;

  initial begin
    n_cmp = 0; n_fail = 0; init = 0; mem_mode = 0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    cycle();
    cycle();

    // Streaming after reset, plus PC wrap on the overridden-reset instance.
    reset = 1'b1;
    #1;
    chk("wrap_addr0", w_imem_addr, WRAP_PC);
    chk("wrap_valid0", {63'b0, w_out_valid}, '0);
    cycle();
    chk("wrap_addr1", w_imem_addr, '0);
    chk("wrap_pc1", w_out_pc, WRAP_PC);
    cycle();
    chk("wrap_pc2", w_out_pc, '0);
    chk("wrap_valid2", {63'b0, w_out_valid}, 64'd1);
    repeat (8) cycle();

    // Backpressure: fill the queue, PC holds at 0x10, then drain in order.
    do_reset();
    out_ready = 1'b0;
    repeat (10) cycle();
    chk("stall_addr", imem_addr, 64'h10);
    out_ready = 1'b1;
    repeat (8) cycle();

    // Redirect with three entries queued.
    mem_mode = 1;
    do_reset();
    out_ready = 1'b0;
    repeat (3) cycle();
    fc_before = fetch_count;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1003;
    cycle();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("redir_fc", {32'b0, fetch_count}, {32'b0, fc_before});
    chk("redir_empty", {63'b0, out_valid}, '0);
    cycle();
    chk("redir_head", out_pc, 64'h1000);
    repeat (4) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = {$urandom(), $urandom()};
      reset          = ($urandom_range(0, 49) != 0);
      cycle();
    end
    reset = 1'b1;
    redirect_valid = 1'b0;

    // Reset with a full queue and a concurrent redirect: reset wins.
    out_ready = 1'b0;
    repeat (6) cycle();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0004;
    cycle();
    reset = 1'b1;
    redirect_valid = 1'b0;
    chk("mid_rst_valid", {63'b0, out_valid}, '0);
    chk("mid_rst_pc", imem_addr, RPC);
    chk("mid_rst_fc", {32'b0, fetch_count}, '0);
    out_ready = 1'b1;
    repeat (5) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
